// File: rtl/rambus_wb_responder.sv
// rtl/rambus_wb_responder.sv - Wishbone classic responder driving one single-port OpenRAM SRAM.
// Define RAMBUS_RDATA_REG_EN to add a register stage on ram_dout0_i (one extra read cycle).
module rambus_wb_responder #(
  parameter int DEPTH        = 256,
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              rambus_wb_stb_i,
  input  logic              rambus_wb_cyc_i,
  input  logic              rambus_wb_we_i,
  input  logic [3:0]        rambus_wb_sel_i,
  input  logic [31:0]       rambus_wb_dat_i,
  input  logic [9:0]        rambus_wb_adr_i,
  output logic              rambus_wb_ack_o,
  output logic [31:0]       rambus_wb_dat_o,
  output logic              ram_csb0_o,
  output logic              ram_web0_o,
  output logic [3:0]        ram_wmask0_o,
  output logic [ADDR_W-1:0] ram_addr0_o,
  output logic [31:0]       ram_din0_o,
  input  logic [31:0]       ram_dout0_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_ISSUE,
    S_READ_WAIT,
    S_ACK
  } state_t;

  localparam logic [10:0] DEPTH_L = 11'(DEPTH);

`ifdef RAMBUS_RDATA_REG_EN
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY);
  logic [31:0] r_rdata_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_rdata_q <= '0;
    else            r_rdata_q <= ram_dout0_i;
  end

  logic [31:0] w_rdata;
  assign w_rdata = r_rdata_q;
`else
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);
  logic [31:0] w_rdata;
  assign w_rdata = ram_dout0_i;
`endif

  state_t     r_state;
  logic [1:0] r_wait_cnt;
  logic       r_abort;

  logic w_req;
  logic w_in_range;
  logic w_access;

  assign w_req      = rambus_wb_stb_i & rambus_wb_cyc_i;
  // Upper address bits are compared, never truncated, so nothing aliases.
  assign w_in_range = ({1'b0, rambus_wb_adr_i} < DEPTH_L);
  assign w_access   = w_in_range & (~rambus_wb_we_i | (rambus_wb_sel_i != 4'd0));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state         <= S_IDLE;
      r_wait_cnt      <= '0;
      r_abort         <= 1'b0;
      rambus_wb_ack_o <= 1'b0;
      rambus_wb_dat_o <= '0;
      ram_csb0_o      <= 1'b1;
      ram_web0_o      <= 1'b1;
      ram_wmask0_o    <= '0;
      ram_addr0_o     <= '0;
      ram_din0_o      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_abort <= 1'b0;
          if (w_req) begin
            if (!w_access) begin
              rambus_wb_ack_o <= 1'b1;
              rambus_wb_dat_o <= '0;
              r_state         <= S_ACK;
            end else if (rambus_wb_we_i) begin
              ram_csb0_o   <= 1'b0;
              ram_web0_o   <= 1'b0;
              ram_wmask0_o <= rambus_wb_sel_i;
              ram_addr0_o  <= rambus_wb_adr_i[ADDR_W-1:0];
              ram_din0_o   <= rambus_wb_dat_i;
              r_state      <= S_WRITE;
            end else begin
              ram_csb0_o  <= 1'b0;
              ram_web0_o  <= 1'b1;
              ram_addr0_o <= rambus_wb_adr_i[ADDR_W-1:0];
              r_state     <= S_READ_ISSUE;
            end
          end
        end
        // The SRAM commits the write on this edge whether or not the master stays.
        S_WRITE: begin
          ram_csb0_o      <= 1'b1;
          ram_web0_o      <= 1'b1;
          rambus_wb_ack_o <= rambus_wb_cyc_i;
          r_state         <= rambus_wb_cyc_i ? S_ACK : S_IDLE;
        end
        S_READ_ISSUE: begin
          ram_csb0_o <= 1'b1;
          r_wait_cnt <= WAIT_INIT;
          if (!rambus_wb_cyc_i) r_abort <= 1'b1;
          r_state    <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            if (r_abort || !rambus_wb_cyc_i) begin
              r_state <= S_IDLE;
            end else begin
              rambus_wb_dat_o <= w_rdata;
              rambus_wb_ack_o <= 1'b1;
              r_state         <= S_ACK;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
            if (!rambus_wb_cyc_i) r_abort <= 1'b1;
          end
        end
        S_ACK: begin
          rambus_wb_ack_o <= 1'b0;
          r_state         <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
